// File: rtl/dm_store_buffer_if.sv
// CPU request/response and DM bus bundle for dm_store_buffer; slave = buffer side, master = CPU/DM side.
interface dm_store_buffer_if #(
  parameter int CNT_W = 3
);
  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_WE;
  logic [7:0]       REQ_ADDR;
  logic [7:0]       REQ_WDATA;
  logic             RSP_VALID;
  logic [7:0]       RSP_RDATA;
  logic             MemRead;
  logic             MemWrite;
  logic [7:0]       ABUS;
  logic [7:0]       DIN;
  logic [7:0]       DATABUS;
  logic             BUF_EMPTY;
  logic [CNT_W-1:0] BUF_COUNT;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, DATABUS,
    output REQ_READY, RSP_VALID, RSP_RDATA, MemRead, MemWrite, ABUS, DIN, BUF_EMPTY, BUF_COUNT
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, DATABUS,
    input  REQ_READY, RSP_VALID, RSP_RDATA, MemRead, MemWrite, ABUS, DIN, BUF_EMPTY, BUF_COUNT
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Store FIFO in front of 8-bit DM: hits return in 1 cycle, misses after drain + IDLE + DM_WAIT; REQ_READY low when full or a miss pends.
// Store-to-load forwarding is enabled by defining DM_STORE_FWD_EN; otherwise loads wait for BUF_EMPTY and read DM.
module dm_store_buffer #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int DM_WAIT = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  dm_store_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

  state_t           state, state_nxt;
  logic [7:0]       fifo_addr [DEPTH];
  logic [7:0]       fifo_data [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [3:0]       wait_cnt, wait_nxt;
  logic             load_pend;
  logic [7:0]       load_addr;
  logic [7:0]       abus, din;
  logic             rsp_valid;
  logic [7:0]       rsp_rdata;
  logic             full, buf_empty, req_ready;
  logic             push, pop, load_acc;
  logic             start_drain, start_load, load_done;
  logic             fwd_hit;
  logic [7:0]       fwd_data;

  assign full      = (count == CNT_W'(DEPTH));
  assign buf_empty = (count == '0) && (state != DRAIN);

  always_comb begin
    req_ready = 1'b0;
    if (!RESET && !load_pend) begin
      if (bus.REQ_WE) begin
        req_ready = !full;
      end else begin
`ifdef DM_STORE_FWD_EN
        req_ready = 1'b1;
`else
        req_ready = buf_empty;
`endif
      end
    end
  end

  assign push     = bus.REQ_VALID && req_ready && bus.REQ_WE;
  assign load_acc = bus.REQ_VALID && req_ready && !bus.REQ_WE;

`ifdef DM_STORE_FWD_EN
  // Walk oldest to youngest so the last match wins; the draining head still counts.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (fifo_addr[head + PTR_W'(i)] == bus.REQ_ADDR)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[head + PTR_W'(i)];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    start_drain = 1'b0;
    start_load  = 1'b0;
    pop         = 1'b0;
    load_done   = 1'b0;
    case (state)
      IDLE: begin
        if (load_pend) begin
          state_nxt  = LOAD;
          wait_nxt   = 4'(DM_WAIT - 1);
          start_load = 1'b1;
        end else if (count != '0) begin
          state_nxt   = DRAIN;
          wait_nxt    = 4'(DM_WAIT - 1);
          start_drain = 1'b1;
        end
      end
      DRAIN: begin
        if (wait_cnt == '0) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      LOAD: begin
        if (wait_cnt == '0) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      load_pend <= 1'b0;
      load_addr <= '0;
      abus      <= '0;
      din       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      rsp_valid <= 1'b0;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (start_drain) begin
        abus <= fifo_addr[head];
        din  <= fifo_data[head];
      end
      if (start_load) abus <= load_addr;
      if (load_acc) begin
        if (fwd_hit) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= fwd_data;
        end else begin
          load_pend <= 1'b1;
          load_addr <= bus.REQ_ADDR;
        end
      end
      if (load_done) begin
        load_pend <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= bus.DATABUS;
      end
    end
  end

  // Entry storage needs no reset: validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[tail] <= bus.REQ_ADDR;
      fifo_data[tail] <= bus.REQ_WDATA;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_rdata;
  assign bus.MemWrite  = (state == DRAIN);
  assign bus.MemRead   = (state == LOAD);
  assign bus.ABUS      = abus;
  assign bus.DIN       = din;
  assign bus.BUF_EMPTY = buf_empty;
  assign bus.BUF_COUNT = count;
endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: reference memory image plus in-order write and response queues.
module tb_dm_store_buffer;
  localparam int W     = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic        clk, rst;
  int          cyc, n_chk, n_fail, rd_total;
  logic [7:0]  dm   [256];
  logic [7:0]  arch [256];
  exp_t        rsp_q[$];
  logic [15:0] wq[$];
  logic [15:0] cur_w;
  bit          in_w;
  int          wlen, rlen;

  dm_store_buffer_if #(.CNT_W(CNT_W)) bus();

  dm_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DM_WAIT(W)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  assign bus.DATABUS = dm[bus.ABUS];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DM model and output monitor; a write lands in dm only once it has been held W cycles.
  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) dm[i] = 8'($urandom);
    dm[8'h40] = 8'h33;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_w = 1'b0;
        wlen = 0;
        rlen = 0;
      end else begin
        if (bus.RSP_VALID === 1'b1) begin
          chk("rsp_expected", 32'(rsp_q.size() != 0), 1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            chk("rsp_data", bus.RSP_RDATA, e.d);
            if (e.c >= 0) chk("rsp_cycle", cyc, e.c);
          end
        end
        if (bus.MemWrite === 1'b1 && !in_w) begin
          chk("wr_expected", 32'(wq.size() != 0), 1);
          cur_w = (wq.size() != 0) ? wq.pop_front() : 16'h0;
          in_w  = 1'b1;
          wlen  = 0;
        end
        if (bus.MemWrite === 1'b1) begin
          wlen++;
          chk("wr_abus", bus.ABUS, cur_w[15:8]);
          chk("wr_din", bus.DIN, cur_w[7:0]);
        end else if (in_w) begin
          chk("wr_len", wlen, W);
          dm[cur_w[15:8]] = cur_w[7:0];
          in_w = 1'b0;
        end
        if (bus.MemRead === 1'b1) begin
          rlen++;
          rd_total++;
        end else if (rlen != 0) begin
          chk("rd_len", rlen, W);
          rlen = 0;
        end
      end
    end
  end

  task automatic sync_arch();
    for (int i = 0; i < 256; i++) arch[i] = dm[i];
  endtask

  task automatic req(input bit we, input logic [7:0] a, input logic [7:0] d,
                     input int lat_rel, input int cyc_abs, output int waited, output int first_cnt);
    int acc;
    exp_t e;
    waited    = 0;
    first_cnt = -1;
    acc       = -1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = a;
    bus.REQ_WDATA = d;
    while (acc < 0 && waited <= 300) begin
      @(negedge clk);
      if (first_cnt < 0) first_cnt = int'(bus.BUF_COUNT);
`ifndef DM_STORE_FWD_EN
      if (!we && bus.BUF_EMPTY !== 1'b1) chk("ld_gate_ready", bus.REQ_READY, 0);
`endif
      if (bus.REQ_READY === 1'b1) acc = cyc;
      else waited++;
    end
    if (acc < 0) begin
      chk("req_timeout", waited, 0);
    end else if (we) begin
      arch[a] = d;
      wq.push_back({a, d});
    end else begin
      e.d = arch[a];
      e.c = (lat_rel >= 0) ? acc + lat_rel : cyc_abs;
      rsp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.BUF_EMPTY === 1'b1 && bus.MemRead === 1'b0 && bus.MemWrite === 1'b0 &&
                 rsp_q.size() == 0) && n < 400);
    if (n >= 400) chk("idle_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mw(output int mw0);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.MemWrite !== 1'b1 && n < 100);
    if (n >= 100) chk("memwrite_timeout", n, 0);
    mw0 = cyc;
  endtask

  initial begin
    int wt, fc, mw0, rd0;
    rst           = 1'b1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b1;
    bus.REQ_ADDR  = 8'h00;
    bus.REQ_WDATA = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.REQ_READY, 0);
    chk("rst_rsp_valid", bus.RSP_VALID, 0);
    chk("rst_rsp_rdata", bus.RSP_RDATA, 0);
    chk("rst_memread", bus.MemRead, 0);
    chk("rst_memwrite", bus.MemWrite, 0);
    chk("rst_abus", bus.ABUS, 0);
    chk("rst_din", bus.DIN, 0);
    chk("rst_buf_empty", bus.BUF_EMPTY, 1);
    chk("rst_buf_count", bus.BUF_COUNT, 0);
    bus.REQ_VALID = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    sync_arch();

    // Reset for two cycles in the middle of a drain.
    req(1'b1, 8'h30, 8'hC1, -1, -1, wt, fc);
    req(1'b1, 8'h31, 8'hC2, -1, -1, wt, fc);
    req(1'b1, 8'h32, 8'hC3, -1, -1, wt, fc);
    wait_mw(mw0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_memwrite_drop", bus.MemWrite, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_memwrite", bus.MemWrite, 0);
    chk("midrst_memread", bus.MemRead, 0);
    chk("midrst_buf_count", bus.BUF_COUNT, 0);
    chk("midrst_buf_empty", bus.BUF_EMPTY, 1);
    chk("midrst_rsp_valid", bus.RSP_VALID, 0);
    wq.delete();
    rsp_q.delete();
    sync_arch();
    wait_idle();

    // Single store timing.
    req(1'b1, 8'h10, 8'hA5, -1, -1, wt, fc);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      chk("st_memwrite", bus.MemWrite, 32'((k >= 2) && (k <= W + 1)));
      if (k == 1) chk("st_count_after_push", bus.BUF_COUNT, 1);
      if (k >= 2 && k <= W + 1) begin
        chk("st_abus", bus.ABUS, 8'h10);
        chk("st_din", bus.DIN, 8'hA5);
      end
      if (k == W + 2) chk("st_buf_empty_after", bus.BUF_EMPTY, 1);
    end
    wait_idle();

    // Fill past DEPTH while the first drain is still in progress.
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 8'(8'h60 + i), 8'(i + 1), -1, -1, wt, fc);
      if (i == 4) begin
        chk("fill_stall", 32'(wt > 0), 1);
        chk("fill_count_full", fc, DEPTH);
      end
    end
    wait_idle();

    // Two stores to one address followed by a load of it.
    rd0 = rd_total;
    req(1'b1, 8'h20, 8'h11, -1, -1, wt, fc);
    req(1'b1, 8'h20, 8'h22, -1, -1, wt, fc);
`ifdef DM_STORE_FWD_EN
    req(1'b0, 8'h20, 8'h00, 1, -1, wt, fc);
    wait_idle();
    chk("fwd_no_memread", rd_total, rd0);
`else
    req(1'b0, 8'h20, 8'h00, W + 2, -1, wt, fc);
    wait_idle();
    chk("nofwd_one_read", rd_total - rd0, W);
`endif

    // Load miss behind a draining store.
    req(1'b1, 8'h50, 8'h77, -1, -1, wt, fc);
    wait_mw(mw0);
    @(posedge clk);
    #1;
`ifdef DM_STORE_FWD_EN
    req(1'b0, 8'h40, 8'h00, -1, mw0 + 2 * W + 1, wt, fc);
`else
    req(1'b0, 8'h40, 8'h00, W + 2, -1, wt, fc);
`endif
    wait_idle();

    // Randomised mix over a small address window so forwarding hits occur.
    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      req(1'($urandom_range(0, 1)), 8'(8'h20 + $urandom_range(0, 5)), 8'($urandom), -1, -1, wt, fc);
    end
    wait_idle();
    chk("end_rsp_q_empty", rsp_q.size(), 0);
    chk("end_wq_empty", wq.size(), 0);
    chk("end_buf_count", bus.BUF_COUNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Synchronous load/store front-end sitting directly upstream of the 8-bit data memory (DM).
- Accepts CPU load/store requests over a valid/ready handshake.
- Posts stores into a small FIFO and drains them to DM over its MemRead/MemWrite/ABUS/DIN/DATABUS interface.
- Services loads by store-to-load forwarding from the FIFO, or by a timed DM read that waits out the DM access delay.

Parameters:
- DEPTH, 4, store FIFO entries; power of two, 2..16.
- CNT_W, 3, width of BUF_COUNT; must satisfy 2^CNT_W > DEPTH.
- DM_WAIT, 2, CLK cycles a DM access is held before DATABUS is sampled or the write is retired; 1..15.

Ports:
- CLK  in  1  clock, rising-edge active.
- RESET  in  1  synchronous active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted this cycle when REQ_VALID&REQ_READY.
- REQ_WE  in  1  1=store, 0=load.
- REQ_ADDR  in  8  byte address.
- REQ_WDATA  in  8  store data.
- RSP_VALID  out  1  one-cycle pulse; load data valid.
- RSP_RDATA  out  8  load data.
- MemRead  out  1  to DM.
- MemWrite  out  1  to DM.
- ABUS  out  8  DM address.
- DIN  out  8  DM write data.
- DATABUS  in  8  DM read data.
- BUF_EMPTY  out  1  FIFO holds no stores and no drain is in flight.
- BUF_COUNT  out  CNT_W  number of occupied FIFO entries, including the entry being drained.

Behaviour:
- Clocking and reset: one clock CLK. RESET is synchronous and active-high, sampled on the rising edge of CLK.
- Reset values:
  - REQ_READY=0, RSP_VALID=0, RSP_RDATA=0.
  - MemRead=0, MemWrite=0, ABUS=0, DIN=0.
  - BUF_EMPTY=1, BUF_COUNT=0.
  - FSM=IDLE; FIFO pointers cleared.
- RESET mid-drain or mid-load aborts the operation: MemWrite and MemRead drop on the next edge, and pending stores are discarded.
- FSM states:
  - IDLE:
    - If a load miss is pending → LOAD.
    - Else if the FIFO is non-empty → DRAIN (head entry).
  - DRAIN:
    - ABUS=head addr, DIN=head data, MemWrite=1 for DM_WAIT cycles.
    - On the last cycle: pop the head, deassert MemWrite → IDLE.
  - LOAD:
    - ABUS=load addr, MemRead=1, wait counter=DM_WAIT.
    - On expiry: capture DATABUS into RSP_RDATA, set RSP_VALID=1 for one cycle, MemRead=0 → IDLE.
  - A drain in progress is never preempted. A pending load miss takes priority over starting the next drain.
- Stores:
  - REQ_READY for a store = FIFO not full and no load miss pending.
  - On accept, push {addr,data} at the tail; BUF_COUNT increments the next cycle.
  - A push and a pop in the same cycle leave BUF_COUNT unchanged.
  - When full (BUF_COUNT==DEPTH), REQ_READY=0 for stores.
  - A store arriving while the FIFO is empty and the FSM is IDLE is still written to the FIFO first; DRAIN starts on the cycle after the push.
- Loads:
  - REQ_READY for a load = no load miss pending.
  - On accept, compare REQ_ADDR against all valid FIFO entries, including the entry being drained.
  - Hit: return the youngest matching data with RSP_VALID=1 on the next cycle (latency 1). The DM is not accessed.
  - Miss: record the load as pending. Latency = remaining drain cycles + 1 (IDLE) + DM_WAIT + 1.
  - Only one load miss may be outstanding.
  - A store and a load cannot be accepted in the same cycle (single request port).
- Pointers: head and tail wrap modulo DEPTH. Full/empty is resolved by BUF_COUNT, not by pointer equality.
- DM bus idle state: MemRead=MemWrite=0; ABUS and DIN hold their last value.
- BUF_EMPTY = (BUF_COUNT==0) && state!=DRAIN.

Optional Feature:
- Macro: DM_STORE_FWD_EN.
- Defined: forwarding behaves as above.
- Undefined:
  - The comparator is removed.
  - Every load waits until BUF_EMPTY=1, then performs a LOAD access.
  - REQ_READY for loads is 0 while the FIFO is non-empty.
  - Data is still coherent because all stores are retired before the read.

Test Plan:
- Reset: assert RESET 2 cycles mid-DRAIN → next cycle MemWrite=0, BUF_COUNT=0, BUF_EMPTY=1, RSP_VALID=0.
- Single store: store addr 0x10 data 0xA5 → MemWrite=1 with ABUS=0x10, DIN=0xA5 for exactly DM_WAIT cycles starting 2 cycles after accept; BUF_EMPTY=1 after.
- Fill: 5 back-to-back stores with DEPTH=4 while DM is slow → 5th sees REQ_READY=0 until first pop; DM writes occur in order 0x01..0x05.
- Forward (macro defined): store 0x20←0x11, store 0x20←0x22, load 0x20 → RSP_RDATA=0x22 one cycle after accept; MemRead never asserted.
- Miss: DM preloaded 0x33 at 0x40, FIFO holds 0x50 entry draining → load 0x40 served after the drain completes, RSP_RDATA=0x33, MemRead held DM_WAIT cycles.
- Macro undefined: 2 stores queued, load 0x20 → REQ_READY=0 until BUF_EMPTY=1, then DM read returns the last stored value.
